// File: rtl/serial_to_par4.sv
// serial_to_par4: serial-to-parallel deserializer.
// Collects one bit per sin_valid cycle, LSB first, and presents each completed
// WIDTH-bit word on pout along with a one-cycle pout_valid strobe.
//
// Parameters:
//   WIDTH       bits per word (2..16)
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   sin         serial data bit
//   sin_valid   sin carries a bit this cycle
//   clear       synchronous abort of the word in progress
//   pout        last completed word (bit0 = first bit received)
//   pout_valid  one-cycle pulse when pout updates
//   busy        1 while a partial word is held
//   all_ones    &pout. Registered only when ALL_ONES_FLAG_EN is defined,
//               otherwise tied to 0.
// Optional feature macro: ALL_ONES_FLAG_EN
module serial_to_par4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  output logic             busy,
  output logic             all_ones
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e           state_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] pout_q;
  logic             pout_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] word_d;
  logic             last_bit;

  // Shift right with new bits entering at the MSB. After WIDTH accepted bits the
  // first one has reached bit0, which gives LSB-first ordering.
  always_comb begin
    word_d   = {sin, shift_q[WIDTH-1:1]};
    last_bit = (state_q == StCollect) && (count_q == LastCnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      count_q      <= '0;
      shift_q      <= '0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pout_valid_q <= 1'b0;
      if (clear) begin
        // Clear overrides any bit arriving in the same cycle. pout is kept.
        state_q <= StIdle;
        count_q <= '0;
        busy_q  <= 1'b0;
      end else if (sin_valid) begin
        shift_q <= word_d;
        if (last_bit) begin
          state_q      <= StIdle;
          count_q      <= '0;
          busy_q       <= 1'b0;
          pout_q       <= word_d;
          pout_valid_q <= 1'b1;
        end else begin
          state_q <= StCollect;
          count_q <= count_q + CntW'(1);
          busy_q  <= 1'b1;
        end
      end
    end
  end

  assign pout       = pout_q;
  assign pout_valid = pout_valid_q;
  assign busy       = busy_q;

`ifdef ALL_ONES_FLAG_EN
  logic all_ones_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      all_ones_q <= 1'b0;
    end else if (sin_valid && !clear && last_bit) begin
      all_ones_q <= &word_d;
    end
  end

  assign all_ones = all_ones_q;
`else
  assign all_ones = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_par4.sv
module tb_serial_to_par4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sin, sin_valid, clear;

  logic [3:0] pout4;
  logic       pv4, busy4, ao4;
  logic [7:0] pout8;
  logic       pv8, busy8, ao8;

  serial_to_par4 #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .pout(pout4), .pout_valid(pv4), .busy(busy4), .all_ones(ao4)
  );

  serial_to_par4 #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .pout(pout8), .pout_valid(pv8), .busy(busy8), .all_ones(ao8)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a list of the bits received so far for each width. When
  // the list reaches the word width, it is packed LSB-first into a word.
  int         mwidth [2] = '{4, 8};
  bit         mbits  [2][$];
  logic [15:0] mpout [2];
  logic        mpv   [2];
  logic        mao   [2];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mbits[i].delete();
        mpout[i] = '0;
        mpv[i]   = 1'b0;
        mao[i]   = 1'b0;
      end else begin
        mpv[i] = 1'b0;
        if (clear) begin
          mbits[i].delete();
        end else if (sin_valid) begin
          mbits[i].push_back(sin);
          if (mbits[i].size() == mwidth[i]) begin
            int unsigned w;
            w = 0;
            for (int k = 0; k < mwidth[i]; k++) w += int'(mbits[i][k]) << k;
            mpout[i] = 16'(w);
            mpv[i]   = 1'b1;
`ifdef ALL_ONES_FLAG_EN
            mao[i] = (w == (32'd1 << mwidth[i]) - 1);
`else
            mao[i] = 1'b0;
`endif
            mbits[i].delete();
          end
        end
      end
    end
  endtask

  task automatic check_all();
    check("pout4",  {12'b0, pout4}, mpout[0]);
    check("pv4",    {15'b0, pv4},   {15'b0, mpv[0]});
    check("busy4",  {15'b0, busy4}, {15'b0, mbits[0].size() != 0});
    check("ao4",    {15'b0, ao4},   {15'b0, mao[0]});
    check("pout8",  {8'b0, pout8},  mpout[1]);
    check("pv8",    {15'b0, pv8},   {15'b0, mpv[1]});
    check("busy8",  {15'b0, busy8}, {15'b0, mbits[1].size() != 0});
    check("ao8",    {15'b0, ao8},   {15'b0, mao[1]});
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model, compare.
  task automatic step(input logic v, input logic s, input logic c, input logic r);
    reset     = r;
    sin_valid = v;
    sin       = s;
    clear     = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send(input logic s);
    step(1'b1, s, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] a5;
    logic [3:0] last4;

    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mpout[i] = '0; mpv[i] = 1'b0; mao[i] = 1'b0;
    end

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    check("rst_pout", {12'b0, pout4}, 16'h0);
    check("rst_pv",   {15'b0, pv4},   16'h0);
    check("rst_busy", {15'b0, busy4}, 16'h0);
    check("rst_ao",   {15'b0, ao4},   16'h0);

    // 1,0,1,1 -> 0xD, with busy visible while bits 2..4 are presented
    send(1'b1);
    check("t2_busy_b2", {15'b0, busy4}, 16'h1);
    send(1'b0);
    send(1'b1);
    check("t2_busy_b4", {15'b0, busy4}, 16'h1);
    send(1'b1);
    check("t2_pout", {12'b0, pout4}, 16'hD);
    check("t2_pv",   {15'b0, pv4},   16'h1);
    check("t2_busy", {15'b0, busy4}, 16'h0);
    idle();
    check("t2_pv_drop", {15'b0, pv4}, 16'h0);
    check("t2_hold",    {12'b0, pout4}, 16'hD);

    // 1,1,gap,gap,1,1 -> 0xF
    send(1'b1); send(1'b1); idle(); idle();
    check("t3_busy_gap", {15'b0, busy4}, 16'h1);
    send(1'b1); send(1'b1);
    check("t3_pout", {12'b0, pout4}, 16'hF);
`ifdef ALL_ONES_FLAG_EN
    check("t3_ao", {15'b0, ao4}, 16'h1);
`else
    check("t3_ao", {15'b0, ao4}, 16'h0);
`endif
    idle();

    // Continuous 0,1,0,0,1,1,1,0 -> 0x2 then 0x7 four cycles later
    send(1'b0); send(1'b1); send(1'b0); send(1'b0);
    check("t4_w0", {12'b0, pout4}, 16'h2);
    check("t4_pv0", {15'b0, pv4}, 16'h1);
    send(1'b1);
    check("t4_pv_mid", {15'b0, pv4}, 16'h0);
    send(1'b1); send(1'b1); send(1'b0);
    check("t4_w1", {12'b0, pout4}, 16'h7);
    check("t4_pv1", {15'b0, pv4}, 16'h1);
    idle();

    // 3 bits, clear, then 1,0,0,0 -> 0x1
    send(1'b1); send(1'b1); send(1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_clr_busy", {15'b0, busy4}, 16'h0);
    check("t5_clr_pout", {12'b0, pout4}, 16'h7);
    send(1'b1); send(1'b0); send(1'b0); send(1'b0);
    check("t5_pout", {12'b0, pout4}, 16'h1);
    idle();

    // Clear together with the 4th bit: no word, pout unchanged
    send(1'b0); send(1'b1); send(1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_last_pv",   {15'b0, pv4},   16'h0);
    check("clr_last_pout", {12'b0, pout4}, 16'h1);
    // Clear in idle has no effect
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_idle_pout", {12'b0, pout4}, 16'h1);

    // Reset after 2 bits, then 0,0,1,1 -> 0xC
    send(1'b1); send(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_rst_pout", {12'b0, pout4}, 16'h0);
    check("t6_rst_busy", {15'b0, busy4}, 16'h0);
    send(1'b0); send(1'b0); send(1'b1); send(1'b1);
    check("t6_pout", {12'b0, pout4}, 16'hC);

    // WIDTH=8: 0xA5 LSB-first
    step(1'b0, 1'b0, 1'b0, 1'b1);
    a5 = 8'hA5;
    for (int k = 0; k < 8; k++) send(a5[k]);
    check("t6_w8",    {8'b0, pout8}, 16'h00A5);
    check("t6_w8_pv", {15'b0, pv8},  16'h1);
    last4 = pout4;
    check("t6_w4_hi", {12'b0, last4}, 16'hA);
    idle();

    // WIDTH=8 all ones
    for (int k = 0; k < 8; k++) send(1'b1);
    check("w8_ff", {8'b0, pout8}, 16'h00FF);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
